// File: rtl/data_memory_pkg.sv
// Shared definitions for the MEM-stage data memory: default geometry,
// byte type and the wrapping lane-index helper.
package data_memory_pkg;

  localparam int DEPTH_BYTES_DEF = 64;
  localparam int DATA_W_DEF      = 64;
  localparam int ADDR_W_DEF      = 64;
  localparam int BYTES_PER_WORD  = 8;
  localparam int IDX_W           = $clog2(DEPTH_BYTES_DEF);

  typedef logic [7:0] byte_t;

  // Byte address of lane k for a doubleword starting at base; wraps at the
  // top of the array (depth is a power of two, so masking is a modulo).
  function automatic int unsigned lane_index(input int unsigned base,
                                             input int unsigned k,
                                             input int unsigned depth);
    return (base + k) & (depth - 1);
  endfunction

endpackage

// File: rtl/data_memory_if.sv
// Load/store bus between the MEM stage and the data memory.
interface data_memory_if
  import data_memory_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
);

  logic [ADDR_W-1:0] Mem_Addr;
  logic [DATA_W-1:0] Write_Data;
  logic              memWrite;
  logic              memRead;
  logic [DATA_W-1:0] Read_Data;

  modport master (
    output Mem_Addr, Write_Data, memWrite, memRead,
    input  Read_Data
  );

  modport slave (
    input  Mem_Addr, Write_Data, memWrite, memRead,
    output Read_Data
  );

endinterface

// File: rtl/data_memory.sv
// Byte-addressable little-endian data memory, one doubleword per access.
// Synchronous writes, combinational reads gated by memRead, address wraps.
// Build option: DATA_MEMORY_PRESET_EN makes reset load mem[i] = i instead of 0.
module data_memory
  import data_memory_pkg::*;
#(
  parameter int DEPTH_BYTES = DEPTH_BYTES_DEF,
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int DATA_W      = DATA_W_DEF
) (
  input logic          clock,
  input logic          reset,
  data_memory_if.slave bus
);

  localparam int LANE_IDX_W = $clog2(DEPTH_BYTES);

  byte_t                 mem [DEPTH_BYTES];
  logic [LANE_IDX_W-1:0] base;
  logic [DATA_W-1:0]     rd_word;
  logic                  unused_addr_hi;

  // Only the low address bits select a byte; the rest are ignored.
  assign base           = bus.Mem_Addr[LANE_IDX_W-1:0];
  assign unused_addr_hi = ^bus.Mem_Addr[ADDR_W-1:LANE_IDX_W];

  // Storage: reset (priority) clears or presets every byte, else store all lanes.
  always_ff @(posedge clock) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH_BYTES; i++) begin
`ifdef DATA_MEMORY_PRESET_EN
        mem[i] <= byte_t'(i);
`else
        mem[i] <= '0;
`endif
      end
    end else if (bus.memWrite) begin
      for (int k = 0; k < BYTES_PER_WORD; k++) begin
        mem[LANE_IDX_W'(lane_index(32'(base), 32'(k), DEPTH_BYTES))] <=
          bus.Write_Data[8*k +: 8];
      end
    end
  end

  // Read path: assemble lanes from current contents, zero when not reading.
  always_comb begin
    rd_word = '0;
    if (bus.memRead) begin
      for (int k = 0; k < BYTES_PER_WORD; k++) begin
        rd_word[8*k +: 8] = mem[LANE_IDX_W'(lane_index(32'(base), 32'(k), DEPTH_BYTES))];
      end
    end
  end

  assign bus.Read_Data = rd_word;

endmodule

// File: tb/tb_data_memory.sv
// Self-checking bench for data_memory: directed cases followed by random
// traffic, compared against a byte-array reference model.
module tb_data_memory;

  logic clock;
  logic reset;

  int n_checks;
  int n_fail;

  logic [7:0] ref_mem [64];

  data_memory_if #(.ADDR_W(64), .DATA_W(64)) bus ();

  data_memory #(.DEPTH_BYTES(64), .ADDR_W(64), .DATA_W(64)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] model_read(input logic [63:0] addr, input logic re);
    logic [63:0] w;
    int          a;
    w = '0;
    if (re) begin
      for (int k = 0; k < 8; k++) begin
        a = (int'(addr % 64) + k) % 64;
        w[8*k +: 8] = ref_mem[a];
      end
    end
    return w;
  endfunction

  function automatic logic [7:0] reset_byte(input int i);
`ifdef DATA_MEMORY_PRESET_EN
    return 8'(i);
`else
    return 8'h00;
`endif
  endfunction

  task automatic model_edge(input logic [63:0] addr, input logic [63:0] wd,
                            input logic we, input logic rst);
    if (!rst) begin
      for (int i = 0; i < 64; i++) ref_mem[i] = reset_byte(i);
    end else if (we) begin
      for (int k = 0; k < 8; k++) ref_mem[(int'(addr % 64) + k) % 64] = wd[8*k +: 8];
    end
  endtask

  // One clock: drive at negedge, check old data before the edge and the
  // updated data just after it with the same inputs held.
  task automatic cycle(input string tag, input logic [63:0] addr, input logic [63:0] wd,
                       input logic we, input logic re, input logic rst);
    @(negedge clock);
    bus.Mem_Addr   = addr;
    bus.Write_Data = wd;
    bus.memWrite   = we;
    bus.memRead    = re;
    reset          = rst;
    #1;
    check_eq({tag, "_pre"}, bus.Read_Data, model_read(addr, re));
    @(posedge clock);
    model_edge(addr, wd, we, rst);
    #1;
    check_eq({tag, "_post"}, bus.Read_Data, model_read(addr, re));
  endtask

  initial begin
    logic [63:0] ra;
    logic [63:0] rw;
    logic        rwe;
    logic        rre;
    logic        rrst;

    n_checks = 0;
    n_fail   = 0;

    // Initial reset: contents undefined beforehand, so no pre-edge check.
    @(negedge clock);
    bus.Mem_Addr   = '0;
    bus.Write_Data = '0;
    bus.memWrite   = 1'b0;
    bus.memRead    = 1'b1;
    reset          = 1'b0;
    @(posedge clock);
    model_edge('0, '0, 1'b0, 1'b0);
    #1;
    check_eq("reset_rd0", bus.Read_Data, model_read(64'd0, 1'b1));

    cycle("rd0",  64'd0,  64'd0, 1'b0, 1'b1, 1'b1);
    cycle("rd40", 64'd40, 64'd0, 1'b0, 1'b1, 1'b1);
`ifndef DATA_MEMORY_PRESET_EN
    check_eq("rd40_zero", bus.Read_Data, 64'h0);
`endif

    cycle("wr10_a", 64'd10, 64'd10, 1'b1, 1'b1, 1'b1);
    check_eq("wr10_a_val", bus.Read_Data, 64'hA);
    cycle("wr10_b", 64'd10, 64'd5, 1'b1, 1'b1, 1'b1);
    check_eq("wr10_b_val", bus.Read_Data, 64'h5);

    cycle("nowr60", 64'd60, 64'd15, 1'b0, 1'b1, 1'b1);
    cycle("wr63_nord", 64'd63, 64'd286, 1'b1, 1'b0, 1'b1);
    check_eq("wr63_nord_zero", bus.Read_Data, 64'h0);
    cycle("rd63_wrap", 64'd63, 64'd0, 1'b0, 1'b1, 1'b1);
    check_eq("rd63_wrap_val", bus.Read_Data[15:0], 16'd286);
    cycle("rd0_wrap", 64'd0, 64'd0, 1'b0, 1'b1, 1'b1);
    check_eq("rd0_wrap_b0", bus.Read_Data[7:0], 8'h01);

    cycle("wr_hi", 64'h1_0000_0008, 64'hDEADBEEF_CAFEF00D, 1'b1, 1'b0, 1'b1);
    cycle("rd8", 64'd8, 64'd0, 1'b0, 1'b1, 1'b1);
    check_eq("rd8_val", bus.Read_Data, 64'hDEADBEEF_CAFEF00D);

    // Random traffic with occasional resets.
    for (int n = 0; n < 400; n++) begin
      ra   = {$urandom, $urandom};
      rw   = {$urandom, $urandom};
      rwe  = 1'($urandom_range(0, 1));
      rre  = ($urandom_range(0, 3) != 0);
      rrst = ($urandom_range(0, 49) != 0);
      cycle("rand", ra, rw, rwe, rre, rrst);
    end

    // Fill some data, then reset with a write asserted: write must be dropped.
    cycle("fill10", 64'd10, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b1, 1'b1);
    cycle("rst_wr", 64'd10, 64'hFF, 1'b1, 1'b1, 1'b0);
    cycle("rd10_after_rst", 64'd10, 64'd0, 1'b0, 1'b1, 1'b1);
`ifdef DATA_MEMORY_PRESET_EN
    check_eq("rd10_rst_val", bus.Read_Data, 64'h11100F0E0D0C0B0A);
`else
    check_eq("rd10_rst_val", bus.Read_Data, 64'h0);
`endif
    for (int a = 0; a < 64; a += 8) cycle("sweep", 64'(a), 64'd0, 1'b0, 1'b1, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
